sc_level_speed_ticker: RTL
==========================

// Module: sc_level_speed_ticker
// PURPOSE
//  Converts the current game level, the count held by the level counter, into a periodic one-cycle
//  movement tick for the lane/car shift registers.
//  - Higher level gives a shorter tick period.
//  - The period has a minimum floor; once it is reached, the block flags maximum speed.
//  - Sits directly downstream of the level counter and upstream of the lane shift logic.
// PARAMETERS
//  LEVEL_WIDTH   8           width of the level input bus
//  PERIOD_WIDTH  26          width of the period and countdown registers (2^26 > 50M cycles)
//  BASE_PERIOD   25_000_000  tick period at level 0, in clock cycles (0.5 s at 50 MHz)
//  STEP_PERIOD   2_000_000   period reduction per level, in cycles
//  MIN_PERIOD    5_000_000   floor period, in cycles; must satisfy 2 <= MIN_PERIOD <= BASE_PERIOD
// PORTS
//  SC_LEVELSPEEDTICKER_CLOCK_50       in   1             system clock, 50 MHz, single clock domain
//  SC_LEVELSPEEDTICKER_RESET_InLow    in   1             asynchronous, active-low reset
//  SC_LEVELSPEEDTICKER_level_InBUS    in   LEVEL_WIDTH   current level from the level counter
//  SC_LEVELSPEEDTICKER_pause_InLow    in   1             0 freezes the countdown; 1 runs it
//  SC_LEVELSPEEDTICKER_tick_OutLow    out  1             registered one-cycle active-low move pulse
//  SC_LEVELSPEEDTICKER_period_OutBUS  out  PERIOD_WIDTH  period currently in force, in cycles
//  SC_LEVELSPEEDTICKER_maxspeed_Out   out  1             1 while the period in force equals MIN_PERIOD
// BEHAVIOUR
//  Clock and reset
//  - Single clock domain. Reset is asynchronous and active-low; this is fixed.
//  Reset values
//  - count = BASE_PERIOD-1; period_reg = BASE_PERIOD.
//  - tick_OutLow = 1; period_OutBUS = BASE_PERIOD; maxspeed_Out = (BASE_PERIOD == MIN_PERIOD).
//  Period calculation (combinational, from the live level input)
//  - prod = level * STEP_PERIOD, computed at LEVEL_WIDTH+PERIOD_WIDTH bits with no truncation.
//  - If prod >= BASE_PERIOD - MIN_PERIOD, then next_period = MIN_PERIOD.
//  - Otherwise next_period = BASE_PERIOD - prod.
//  Countdown, on each rising edge with pause_InLow = 1
//  - If count != 0: count decrements by 1, and tick_OutLow = 1.
//  - If count == 0:
//    - tick_OutLow = 0 for exactly the next cycle;
//    - period_reg <= next_period;
//    - count <= next_period - 1.
//  - Consecutive ticks are therefore exactly period_reg enabled cycles apart.
//  - The first tick comes on the BASE_PERIOD-th enabled edge after reset release.
//  Level sampling
//  - The level is sampled only at reload, i.e. on the edge that produces a tick.
//  - A level change mid-period does not shorten the period in progress.
//  - A level change takes effect from the following period.
//  - Glitches on the level input between reloads are ignored.
//  Pause (pause_InLow = 0)
//  - count and period_reg hold their values.
//  - tick_OutLow = 1.
//  - A tick that was due is deferred until the pause is released; it is never lost or duplicated.
//  Outputs
//  - period_OutBUS = period_reg.
//  - maxspeed_Out = (period_reg == MIN_PERIOD).
//  - Both outputs are registered and change only on the reload edge.
//  Boundaries
//  - The level wrapping from 255 to 0 in the upstream counter restores BASE_PERIOD at the next reload.
//  - Reset asserted mid-period aborts the period immediately; the block restarts from the reset values.
//  - Reset has priority over pause.
// STRUCTURE
//  Shared package, included by this block, the level counter and the lane logic:
//  - LEVEL_WIDTH, PERIOD_WIDTH, BASE_PERIOD, STEP_PERIOD and MIN_PERIOD defaults.
//  Sub-module: sc_level_period_calc
//  - Purely combinational: level in, next_period out, including the clamp.
//  - Instantiated once here so the product and clamp can be unit-tested alone.
//  This block: countdown register, period register and registered tick/flag outputs.
// TESTING
//  All scenarios use parameters BASE=10, STEP=2, MIN=4, LEVEL_WIDTH=4, PERIOD_WIDTH=8.
//  1. Reset then level=0 -> first tick on the 10th edge after release, then every 10 cycles;
//     period_OutBUS=10, maxspeed=0.
//  2. Level=2 held from reset -> first period is 10 (reset value); after that, ticks every
//     6 cycles and period_OutBUS=6.
//  3. Level=5 (prod 10 >= 6) -> after the first reload, period=4, maxspeed=1, ticks every 4 cycles;
//     level=15 gives the same result with no overflow.
//  4. Level changes from 0 to 3 at cycle 4 of a 10-cycle period -> that tick still lands at
//     cycle 10; the next gap is 4 cycles.
//  5. pause_InLow=0 for 7 cycles starting when count=1 -> no tick while paused; the tick comes
//     2 enabled edges after release, and there is exactly one tick.
//  6. Reset asserted at count=3, mid-period -> outputs return immediately to the reset values;
//     the next tick comes 10 edges after release.

Source files
------------

// File: rtl/sc_level_speed_ticker_pkg.sv
// Shared defaults for the level counter, the speed ticker and the lane logic.
// The widths and periods here are the 50 MHz production values.
package sc_level_speed_ticker_pkg;

  localparam int SC_LEVEL_WIDTH  = 8;
  localparam int SC_PERIOD_WIDTH = 26;
  localparam int SC_BASE_PERIOD  = 25_000_000;
  localparam int SC_STEP_PERIOD  = 2_000_000;
  localparam int SC_MIN_PERIOD   = 5_000_000;

endpackage

// File: rtl/sc_level_speed_ticker_if.sv
// Level/pause inputs and tick/period/maxspeed outputs of the speed ticker.
// The master side is the game control; the slave side is the ticker.
interface sc_level_speed_ticker_if #(
  parameter int LEVEL_WIDTH  = sc_level_speed_ticker_pkg::SC_LEVEL_WIDTH,
  parameter int PERIOD_WIDTH = sc_level_speed_ticker_pkg::SC_PERIOD_WIDTH
);
  logic [LEVEL_WIDTH-1:0]  SC_LEVELSPEEDTICKER_level_InBUS;
  logic                    SC_LEVELSPEEDTICKER_pause_InLow;
  logic                    SC_LEVELSPEEDTICKER_tick_OutLow;
  logic [PERIOD_WIDTH-1:0] SC_LEVELSPEEDTICKER_period_OutBUS;
  logic                    SC_LEVELSPEEDTICKER_maxspeed_Out;

  modport master (
    output SC_LEVELSPEEDTICKER_level_InBUS,
    output SC_LEVELSPEEDTICKER_pause_InLow,
    input  SC_LEVELSPEEDTICKER_tick_OutLow,
    input  SC_LEVELSPEEDTICKER_period_OutBUS,
    input  SC_LEVELSPEEDTICKER_maxspeed_Out
  );

  modport slave (
    input  SC_LEVELSPEEDTICKER_level_InBUS,
    input  SC_LEVELSPEEDTICKER_pause_InLow,
    output SC_LEVELSPEEDTICKER_tick_OutLow,
    output SC_LEVELSPEEDTICKER_period_OutBUS,
    output SC_LEVELSPEEDTICKER_maxspeed_Out
  );
endinterface

// File: rtl/sc_level_speed_ticker_sc_level_period_calc.sv
// Combinational level -> period mapping with the floor clamp.
// The product is kept at full width so large levels can never wrap past the clamp.
module sc_level_period_calc
  import sc_level_speed_ticker_pkg::*;
#(
  parameter int LEVEL_WIDTH  = SC_LEVEL_WIDTH,
  parameter int PERIOD_WIDTH = SC_PERIOD_WIDTH,
  parameter int BASE_PERIOD  = SC_BASE_PERIOD,
  parameter int STEP_PERIOD  = SC_STEP_PERIOD,
  parameter int MIN_PERIOD   = SC_MIN_PERIOD
) (
  input  logic [LEVEL_WIDTH-1:0]  level,
  output logic [PERIOD_WIDTH-1:0] next_period
);

  localparam int PROD_WIDTH = LEVEL_WIDTH + PERIOD_WIDTH;

  logic [PROD_WIDTH-1:0] prod;

  always_comb begin
    prod        = PROD_WIDTH'(level) * PROD_WIDTH'(STEP_PERIOD);
    next_period = PERIOD_WIDTH'(MIN_PERIOD);
    if (prod < PROD_WIDTH'(BASE_PERIOD - MIN_PERIOD)) begin
      next_period = PERIOD_WIDTH'(BASE_PERIOD) - prod[PERIOD_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/sc_level_speed_ticker.sv
// Level-dependent movement ticker: down-counter reloaded from the level at each tick,
// with registered active-low tick, period-in-force and max-speed flag.
module sc_level_speed_ticker
  import sc_level_speed_ticker_pkg::*;
#(
  parameter int LEVEL_WIDTH  = SC_LEVEL_WIDTH,
  parameter int PERIOD_WIDTH = SC_PERIOD_WIDTH,
  parameter int BASE_PERIOD  = SC_BASE_PERIOD,
  parameter int STEP_PERIOD  = SC_STEP_PERIOD,
  parameter int MIN_PERIOD   = SC_MIN_PERIOD
) (
  input  logic                    SC_LEVELSPEEDTICKER_CLOCK_50,
  input  logic                    SC_LEVELSPEEDTICKER_RESET_InLow,
  sc_level_speed_ticker_if.slave  bus
);

  logic [PERIOD_WIDTH-1:0] next_period;
  logic [PERIOD_WIDTH-1:0] count_q, count_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    tick_q, tick_d;
  logic                    maxspeed_q, maxspeed_d;

  sc_level_period_calc #(
    .LEVEL_WIDTH  (LEVEL_WIDTH),
    .PERIOD_WIDTH (PERIOD_WIDTH),
    .BASE_PERIOD  (BASE_PERIOD),
    .STEP_PERIOD  (STEP_PERIOD),
    .MIN_PERIOD   (MIN_PERIOD)
  ) u_period_calc (
    .level       (bus.SC_LEVELSPEEDTICKER_level_InBUS),
    .next_period (next_period)
  );

  // The level is only looked at on the reload edge, so mid-period changes wait a period.
  always_comb begin
    count_d    = count_q;
    period_d   = period_q;
    maxspeed_d = maxspeed_q;
    tick_d     = 1'b1;
    if (bus.SC_LEVELSPEEDTICKER_pause_InLow) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end else begin
        tick_d     = 1'b0;
        period_d   = next_period;
        count_d    = next_period - 1'b1;
        maxspeed_d = (next_period == PERIOD_WIDTH'(MIN_PERIOD));
      end
    end
  end

  always_ff @(posedge SC_LEVELSPEEDTICKER_CLOCK_50 or negedge SC_LEVELSPEEDTICKER_RESET_InLow) begin
    if (!SC_LEVELSPEEDTICKER_RESET_InLow) begin
      count_q    <= PERIOD_WIDTH'(BASE_PERIOD - 1);
      period_q   <= PERIOD_WIDTH'(BASE_PERIOD);
      tick_q     <= 1'b1;
      maxspeed_q <= (BASE_PERIOD == MIN_PERIOD);
    end else begin
      count_q    <= count_d;
      period_q   <= period_d;
      tick_q     <= tick_d;
      maxspeed_q <= maxspeed_d;
    end
  end

  assign bus.SC_LEVELSPEEDTICKER_tick_OutLow    = tick_q;
  assign bus.SC_LEVELSPEEDTICKER_period_OutBUS  = period_q;
  assign bus.SC_LEVELSPEEDTICKER_maxspeed_Out   = maxspeed_q;

endmodule
